// File: rtl/taglist_pkg.sv
// Shared definitions for the tag-list scanner: ROM marker codes, FSM states
// and the tag-word width helper.
package taglist_pkg;

  // Two marker bits accompany every ROM word; 2'b10 is treated as mid-segment.
  localparam logic [1:0] MK_MID      = 2'b00;
  localparam logic [1:0] MK_SEG_END  = 2'b01;
  localparam logic [1:0] MK_RSVD     = 2'b10;
  localparam logic [1:0] MK_LIST_END = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SCAN  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Tag word layout: {seq, start address, end address, last flag}.
  function automatic int ram_w(input int seq_w, input int addr_w);
    return seq_w + 2 * addr_w + 1;
  endfunction

endpackage

// File: rtl/taglist_scanner_if.sv
// Bus bundle between the scanner and its ROM/RAM environment. The scanner is
// the master: it issues ROM addresses and RAM writes.
interface taglist_scanner_if #(
  parameter int ADDR_W = 10,
  parameter int SEQ_W  = 7
);
  import taglist_pkg::*;

  localparam int RAM_W = ram_w(SEQ_W, ADDR_W);

  logic                start;
  logic [1:0]          lastEnd;
  logic [ADDR_W-1:0]   seqWire;
  logic [RAM_W-1:0]    ramData;
  logic [SEQ_W-1:0]    seqNum;
  logic                w_e_RAM;
  logic                busy;
  logic                done;
  logic [1:0]          err;
  logic [SEQ_W:0]      tag_count;

  modport master (
    input  start, lastEnd,
    output seqWire, ramData, seqNum, w_e_RAM, busy, done, err, tag_count
  );

  modport slave (
    output start, lastEnd,
    input  seqWire, ramData, seqNum, w_e_RAM, busy, done, err, tag_count
  );

endinterface

// File: rtl/taglist_addr_pipe.sv
// Delay line that carries each issued ROM address (and its valid bit) for
// ROM_LAT cycles, so the scanner knows which address the current marker
// bits belong to.
module taglist_addr_pipe #(
  parameter int ADDR_W  = 10,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_1KHz,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              vld_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              vld_o
);

  logic [ADDR_W-1:0]  addr_q [ROM_LAT];
  logic [ROM_LAT-1:0] vld_q;

  // Shift address/valid one stage per clock.
  always_ff @(posedge clk_1KHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROM_LAT; i++) addr_q[i] <= '0;
      vld_q <= '0;
    end else begin
      addr_q[0] <= addr_i;
      vld_q[0]  <= vld_i;
      for (int i = 1; i < ROM_LAT; i++) begin
        addr_q[i] <= addr_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign addr_o = addr_q[ROM_LAT-1];
  assign vld_o  = vld_q[ROM_LAT-1];

endmodule

// File: rtl/taglist_scanner.sv
// Walks a marker ROM from address 0, cutting it into segments at 01/11
// markers and writing one tag word per segment into a RAM.
module taglist_scanner
  import taglist_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int SEQ_W   = 7,
  parameter int ROM_LAT = 1
) (
  input  logic               clk_1KHz,
  input  logic               reset,
  taglist_scanner_if.master  bus
);

  localparam int RAM_W = ram_w(SEQ_W, ADDR_W);

  state_e             state_q, state_d;
  logic [1:0]         prime_cnt_q, prime_cnt_d;
  logic [ADDR_W-1:0]  seqWire_q, seqWire_d;
  logic [ADDR_W-1:0]  seg_start_q, seg_start_d;
  logic [SEQ_W-1:0]   index_q, index_d;
  logic [SEQ_W:0]     tag_count_q, tag_count_d;
  logic [RAM_W-1:0]   ramData_q, ramData_d;
  logic [SEQ_W-1:0]   seqNum_q, seqNum_d;
  logic               w_e_q, w_e_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               term_q, term_d;

  logic [ADDR_W-1:0]  a_d;
  logic               vld_d;
  logic               issue;
  logic               at_top, seg_end, list_end, last;
  logic [SEQ_W-1:0]   seq_field;

  // Address increment that parks at the top of the ROM instead of wrapping.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  assign issue = (state_q == ST_PRIME) || (state_q == ST_SCAN);

  taglist_addr_pipe #(
    .ADDR_W  (ADDR_W),
    .ROM_LAT (ROM_LAT)
  ) u_addr_pipe (
    .clk_1KHz (clk_1KHz),
    .reset    (reset),
    .addr_i   (seqWire_q),
    .vld_i    (issue),
    .addr_o   (a_d),
    .vld_o    (vld_d)
  );

  // State and output registers.
  always_ff @(posedge clk_1KHz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prime_cnt_q <= '0;
      seqWire_q   <= '0;
      seg_start_q <= '0;
      index_q     <= '0;
      tag_count_q <= '0;
      ramData_q   <= '0;
      seqNum_q    <= '0;
      w_e_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      term_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      seqWire_q   <= seqWire_d;
      seg_start_q <= seg_start_d;
      index_q     <= index_d;
      tag_count_q <= tag_count_d;
      ramData_q   <= ramData_d;
      seqNum_q    <= seqNum_d;
      w_e_q       <= w_e_d;
      done_q      <= done_d;
      err_q       <= err_d;
      term_q      <= term_d;
    end
  end

  // Next-state logic: prime the ROM pipeline, then decode one marker per cycle.
  // A terminating write keeps the FSM in SCAN for its write cycle (term_q) so
  // the strobe never coincides with FIN; the words still in flight are dropped.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    seqWire_d   = seqWire_q;
    seg_start_d = seg_start_q;
    index_d     = index_q;
    tag_count_d = tag_count_q;
    ramData_d   = ramData_q;
    seqNum_d    = seqNum_q;
    w_e_d       = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    term_d      = term_q;
    at_top      = (a_d == '1);
    seg_end     = (bus.lastEnd == MK_SEG_END);
    list_end    = (bus.lastEnd == MK_LIST_END);
    last        = 1'b0;
    seq_field   = index_q + 1'b1;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (bus.start) begin
          state_d     = ST_PRIME;
          prime_cnt_d = '0;
          seqWire_d   = '0;
          seg_start_d = '0;
          index_d     = '0;
          tag_count_d = '0;
          done_d      = 1'b0;
          err_d       = '0;
          term_d      = 1'b0;
        end
      end
      ST_PRIME: begin
        seqWire_d   = next_addr(seqWire_q);
        prime_cnt_d = prime_cnt_q + 2'd1;
        if (prime_cnt_q == 2'(ROM_LAT - 1)) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (term_q) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          seqWire_d = next_addr(seqWire_q);
          if (vld_d && (seg_end || list_end || at_top)) begin
            last        = list_end || at_top || (index_q == '1);
            w_e_d       = 1'b1;
            seqNum_d    = index_q;
            ramData_d   = {seq_field, seg_start_q, a_d, last};
            seg_start_d = a_d + 1'b1;
            index_d     = index_q + 1'b1;
            tag_count_d = tag_count_q + 1'b1;
            term_d      = last;
            if (seg_end && (index_q == '1)) err_d[0] = 1'b1;
            if (at_top && !list_end)        err_d[1] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.seqWire   = seqWire_q;
  assign bus.ramData   = ramData_q;
  assign bus.seqNum    = seqNum_q;
  assign bus.w_e_RAM   = w_e_q;
  assign bus.busy      = issue;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tag_count = tag_count_q;

endmodule

// File: tb/tb_taglist_scanner.sv
// Directed bench: four scanner instances (default, ROM_LAT=3, SEQ_W=2,
// ADDR_W=4) each fed by a small behavioural ROM with a matching latency.
module tb_taglist_scanner;
  import taglist_pkg::*;

  logic clk_1KHz = 1'b0;
  logic reset;
  always #5 clk_1KHz = ~clk_1KHz;

  taglist_scanner_if #(.ADDR_W(10), .SEQ_W(7)) ifa ();
  taglist_scanner_if #(.ADDR_W(10), .SEQ_W(7)) ifb ();
  taglist_scanner_if #(.ADDR_W(10), .SEQ_W(2)) ifc ();
  taglist_scanner_if #(.ADDR_W(4),  .SEQ_W(7)) ifd ();

  taglist_scanner #(.ADDR_W(10), .SEQ_W(7), .ROM_LAT(1)) dut_a (
    .clk_1KHz(clk_1KHz), .reset(reset), .bus(ifa.master));
  taglist_scanner #(.ADDR_W(10), .SEQ_W(7), .ROM_LAT(3)) dut_b (
    .clk_1KHz(clk_1KHz), .reset(reset), .bus(ifb.master));
  taglist_scanner #(.ADDR_W(10), .SEQ_W(2), .ROM_LAT(1)) dut_c (
    .clk_1KHz(clk_1KHz), .reset(reset), .bus(ifc.master));
  taglist_scanner #(.ADDR_W(4), .SEQ_W(7), .ROM_LAT(1)) dut_d (
    .clk_1KHz(clk_1KHz), .reset(reset), .bus(ifd.master));

  logic [1:0] rom_a [0:1023];
  logic [1:0] rom_b [0:1023];
  logic [1:0] rom_c [0:1023];
  logic [1:0] rom_d [0:15];
  logic [1:0] rb1, rb2;

  // ROM models: one-cycle read for a/c/d, three-cycle read for b.
  always @(posedge clk_1KHz) begin
    ifa.lastEnd <= rom_a[ifa.seqWire];
    rb1         <= rom_b[ifb.seqWire];
    rb2         <= rb1;
    ifb.lastEnd <= rb2;
    ifc.lastEnd <= rom_c[ifc.seqWire];
    ifd.lastEnd <= rom_d[ifd.seqWire];
  end

  int cyc = 0;
  always @(posedge clk_1KHz) cyc <= cyc + 1;

  logic [63:0] qa_d[$], qb_d[$], qc_d[$], qd_d[$];
  int          qa_n[$], qb_n[$], qc_n[$];
  int          qa_c[$], qb_c[$];
  int          stray_a = 0;

  // Capture every RAM write away from the active edge.
  always @(negedge clk_1KHz) begin
    if (ifa.w_e_RAM) begin
      qa_d.push_back(64'(ifa.ramData)); qa_n.push_back(int'(ifa.seqNum)); qa_c.push_back(cyc);
      if (!ifa.busy) stray_a = stray_a + 1;
    end
    if (ifb.w_e_RAM) begin
      qb_d.push_back(64'(ifb.ramData)); qb_n.push_back(int'(ifb.seqNum)); qb_c.push_back(cyc);
    end
    if (ifc.w_e_RAM) begin
      qc_d.push_back(64'(ifc.ramData)); qc_n.push_back(int'(ifc.seqNum));
    end
    if (ifd.w_e_RAM) qd_d.push_back(64'(ifd.ramData));
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tw(input int aw, input int seq, input int st,
                                     input int en, input int last);
    logic [63:0] r;
    r = 64'(seq);
    r = (r << aw) | 64'(st);
    r = (r << aw) | 64'(en);
    r = (r << 1)  | 64'(last);
    return r;
  endfunction

  task automatic load_main_rom();
    for (int i = 0; i < 1024; i++) begin rom_a[i] = 2'b00; rom_b[i] = 2'b00; end
    rom_a[5] = 2'b01; rom_a[12] = 2'b01; rom_a[21] = 2'b01; rom_a[42] = 2'b01; rom_a[63] = 2'b11;
    rom_b[5] = 2'b01; rom_b[12] = 2'b01; rom_b[21] = 2'b01; rom_b[42] = 2'b01; rom_b[63] = 2'b11;
    rom_a[100] = 2'b01;
  endtask

  task automatic clear_q();
    qa_d.delete(); qa_n.delete(); qa_c.delete();
    qb_d.delete(); qb_n.delete(); qb_c.delete();
    qc_d.delete(); qc_n.delete(); qd_d.delete();
  endtask

  task automatic pulse_start_a();
    @(negedge clk_1KHz); ifa.start = 1'b1;
    @(negedge clk_1KHz); ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int k = 0;
    while (!ifa.done && k < budget) begin @(posedge clk_1KHz); #1; k++; end
    chk({tag, "_done_in_time"}, 64'(ifa.done), 64'd1);
  endtask

  task automatic check_main_a(input string tag);
    int st[5] = '{0, 6, 13, 22, 43};
    int en[5] = '{5, 12, 21, 42, 63};
    chk({tag, "_nwr"}, 64'(qa_d.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < qa_d.size()) begin
        chk($sformatf("%s_wr%0d", tag, i), qa_d[i], tw(10, i + 1, st[i], en[i], (i == 4) ? 1 : 0));
        chk($sformatf("%s_seqnum%0d", tag, i), 64'(qa_n[i]), 64'(i));
      end
    end
    chk({tag, "_err"}, 64'(ifa.err), 64'd0);
    chk({tag, "_tag_count"}, 64'(ifa.tag_count), 64'd5);
    chk({tag, "_busy"}, 64'(ifa.busy), 64'd0);
    chk({tag, "_stray_we"}, 64'(stray_a), 64'd0);
  endtask

  initial begin
    int k;
    int st[5] = '{0, 6, 13, 22, 43};
    int en[5] = '{5, 12, 21, 42, 63};
    reset = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; ifd.start = 1'b0;
    load_main_rom();
    for (int i = 0; i < 1024; i++) rom_c[i] = 2'b00;
    rom_c[1] = 2'b01; rom_c[3] = 2'b01; rom_c[5] = 2'b01; rom_c[7] = 2'b01; rom_c[9] = 2'b01;
    for (int i = 0; i < 16; i++) rom_d[i] = (i == 7) ? 2'b10 : 2'b00;

    repeat (3) @(posedge clk_1KHz);
    #1;
    chk("rst_seqWire", 64'(ifa.seqWire), 64'd0);
    chk("rst_ramData", 64'(ifa.ramData), 64'd0);
    chk("rst_seqNum", 64'(ifa.seqNum), 64'd0);
    chk("rst_we", 64'(ifa.w_e_RAM), 64'd0);
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_done", 64'(ifa.done), 64'd0);
    chk("rst_err", 64'(ifa.err), 64'd0);
    chk("rst_tag_count", 64'(ifa.tag_count), 64'd0);
    @(negedge clk_1KHz); reset = 1'b0;

    // Parallel run of all four instances.
    @(negedge clk_1KHz);
    ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1; ifd.start = 1'b1;
    @(negedge clk_1KHz);
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; ifd.start = 1'b0;
    k = 0;
    while (!(ifa.done && ifb.done && ifc.done && ifd.done) && k < 3000) begin
      @(posedge clk_1KHz); #1; k++;
    end
    chk("all_done_in_time", 64'(ifa.done && ifb.done && ifc.done && ifd.done), 64'd1);

    check_main_a("lat1");

    chk("lat3_nwr", 64'(qb_d.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < qb_d.size() && i < qa_c.size()) begin
        chk($sformatf("lat3_wr%0d", i), qb_d[i], tw(10, i + 1, st[i], en[i], (i == 4) ? 1 : 0));
        chk($sformatf("lat3_seqnum%0d", i), 64'(qb_n[i]), 64'(i));
        chk($sformatf("lat3_delay%0d", i), 64'(qb_c[i] - qa_c[i]), 64'd2);
      end
    end
    chk("lat3_err", 64'(ifb.err), 64'd0);
    chk("lat3_tag_count", 64'(ifb.tag_count), 64'd5);

    chk("ovf_nwr", 64'(qc_d.size()), 64'd4);
    if (qc_d.size() == 4) begin
      chk("ovf_wr0", qc_d[0], tw(10, 1, 0, 1, 0));
      chk("ovf_wr2", qc_d[2], tw(10, 3, 4, 5, 0));
      chk("ovf_wr3", qc_d[3], tw(10, 0, 6, 7, 1));
      chk("ovf_seqnum3", 64'(qc_n[3]), 64'd3);
    end
    chk("ovf_err", 64'(ifc.err), 64'd1);
    chk("ovf_tag_count", 64'(ifc.tag_count), 64'd4);

    chk("noterm_nwr", 64'(qd_d.size()), 64'd1);
    if (qd_d.size() == 1) chk("noterm_wr0", qd_d[0], tw(4, 1, 0, 15, 1));
    chk("noterm_err", 64'(ifd.err), 64'd2);
    chk("noterm_done", 64'(ifd.done), 64'd1);
    chk("noterm_seqWire", 64'(ifd.seqWire), 64'd15);

    // Adjacent one-word segments, no list terminator.
    clear_q();
    for (int i = 0; i < 1024; i++) rom_a[i] = 2'b00;
    rom_a[2] = 2'b01; rom_a[3] = 2'b01;
    pulse_start_a();
    #1;
    chk("b2b_done_cleared", 64'(ifa.done), 64'd0);
    wait_done_a("b2b", 1500);
    chk("b2b_nwr", 64'(qa_d.size()), 64'd3);
    if (qa_d.size() == 3) begin
      chk("b2b_wr0", qa_d[0], tw(10, 1, 0, 2, 0));
      chk("b2b_wr1", qa_d[1], tw(10, 2, 3, 3, 0));
      chk("b2b_gap", 64'(qa_c[1] - qa_c[0]), 64'd1);
      chk("b2b_wr2", qa_d[2], tw(10, 3, 4, 1023, 1));
    end
    chk("b2b_err", 64'(ifa.err), 64'd2);

    // Mid-scan start is ignored, reset after the second write aborts.
    clear_q();
    load_main_rom();
    pulse_start_a();
    k = 0;
    while (qa_d.size() < 1 && k < 200) begin @(posedge clk_1KHz); #1; k++; end
    chk("abort_wr1_seen", 64'(qa_d.size() >= 1), 64'd1);
    pulse_start_a();
    k = 0;
    while (qa_d.size() < 2 && k < 200) begin @(posedge clk_1KHz); #1; k++; end
    chk("abort_wr2_seen", 64'(qa_d.size() >= 2), 64'd1);
    if (qa_d.size() >= 2) begin
      chk("abort_wr1", qa_d[1], tw(10, 2, 6, 12, 0));
      chk("abort_seqnum1", 64'(qa_n[1]), 64'd1);
    end
    reset = 1'b1;
    #1;
    chk("abort_seqWire", 64'(ifa.seqWire), 64'd0);
    chk("abort_ramData", 64'(ifa.ramData), 64'd0);
    chk("abort_seqNum", 64'(ifa.seqNum), 64'd0);
    chk("abort_we", 64'(ifa.w_e_RAM), 64'd0);
    chk("abort_busy", 64'(ifa.busy), 64'd0);
    chk("abort_tag_count", 64'(ifa.tag_count), 64'd0);
    repeat (3) @(posedge clk_1KHz);
    @(negedge clk_1KHz); reset = 1'b0;
    repeat (80) @(posedge clk_1KHz);
    #1;
    chk("abort_idle_busy", 64'(ifa.busy), 64'd0);
    chk("abort_no_wr3", 64'(qa_d.size()), 64'd2);

    clear_q();
    pulse_start_a();
    wait_done_a("rerun", 300);
    check_main_a("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
